// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
// Shared constants and types for the UART receive FIFO slice:
//   UART_DATA_W     - byte width carried through the FIFO
//   FIFO_DEPTH_DEF  - default number of entries
//   FIFO_AW_DEF     - default address width, log2(FIFO_DEPTH_DEF)
//   Q_RST_VAL       - value of the read data register after reset
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned FIFO_AW_DEF    = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  localparam uart_byte_t Q_RST_VAL = '0;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// uart_rx_fifo_ram
// Simple dual-port byte array: one synchronous write port, one registered
// read port. Array contents are not reset; only the read register is.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds its value when low
//   raddr  in   read address
//   rdata  out  registered read data
module uart_rx_fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AW    = FIFO_AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_byte_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output uart_byte_t    rdata
);

  uart_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= Q_RST_VAL;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Byte FIFO between the UART receiver and its consumer. The receiver cannot
// be stalled, so writes arriving while full are dropped rather than blocked.
// Optional overrun reporting is enabled by defining UART_RX_FIFO_OVF_EN.
// Ports:
//   uart_clk  in   single clock shared with the receiver
//   rst_n     in   asynchronous active-low reset
//   fr_wrreq  in   one-cycle write strobe per received byte
//   rf_data   in   received byte, valid with fr_wrreq
//   rdreq     in   pop request
//   q         out  registered read data
//   q_valid   out  one-cycle pulse when q holds a newly popped byte
//   empty     out  no entries stored
//   full      out  DEPTH entries stored
//   usedw     out  entry count, 0..DEPTH
//   ovf       out  sticky overrun flag          (UART_RX_FIFO_OVF_EN only)
//   drop_cnt  out  saturating dropped-byte count (UART_RX_FIFO_OVF_EN only)
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AW    = FIFO_AW_DEF
) (
  input  logic                   uart_clk,
  input  logic                   rst_n,
  input  logic                   fr_wrreq,
  input  logic [UART_DATA_W-1:0] rf_data,
  input  logic                   rdreq,
  output logic [UART_DATA_W-1:0] q,
  output logic                   q_valid,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            usedw
`ifdef UART_RX_FIFO_OVF_EN
  ,
  output logic                   ovf,
  output logic [7:0]             drop_cnt
`endif
);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        wr_ok;
  logic        rd_ok;

  always_comb begin
    empty = (wp == rp);
    full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    usedw = wp - rp;
    // Both qualifiers use pre-edge flags: a read in the same cycle never
    // frees room for a write, and a write never feeds a read.
    wr_ok = fr_wrreq && !full;
    rd_ok = rdreq && !empty;
  end

  uart_rx_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (uart_clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wp[AW-1:0]),
    .wdata (rf_data),
    .re    (rd_ok),
    .raddr (rp[AW-1:0]),
    .rdata (q)
  );

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      q_valid <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= rp + 1'b1;
      end
      q_valid <= rd_ok;
    end
  end

`ifdef UART_RX_FIFO_OVF_EN
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (fr_wrreq && full) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        uart_clk;
  logic        rst_n;
  logic        fr_wrreq;
  logic [7:0]  rf_data;
  logic        rdreq;
  logic [7:0]  q;
  logic        q_valid;
  logic        empty;
  logic        full;
  logic [AW:0] usedw;
`ifdef UART_RX_FIFO_OVF_EN
  logic        ovf;
  logic [7:0]  drop_cnt;
`endif

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .fr_wrreq (fr_wrreq),
    .rf_data  (rf_data),
    .rdreq    (rdreq),
    .q        (q),
    .q_valid  (q_valid),
    .empty    (empty),
    .full     (full),
    .usedw    (usedw)
`ifdef UART_RX_FIFO_OVF_EN
    ,
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
`endif
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Behavioural reference: a queue of bytes plus the last popped byte.
  byte unsigned mq[$];
  logic [7:0]   m_q;
  logic         m_qv;
  logic         m_ovf;
  int unsigned  m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_q    = 8'h00;
    m_qv   = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},       {24'd0, q},           {24'd0, m_q});
    chk({tag, ".q_valid"}, {31'd0, q_valid},     {31'd0, m_qv});
    chk({tag, ".empty"},   {31'd0, empty},       {31'd0, (mq.size() == 0)});
    chk({tag, ".full"},    {31'd0, full},        {31'd0, (mq.size() == DEPTH)});
    chk({tag, ".usedw"},   {27'd0, usedw},       mq.size());
`ifdef UART_RX_FIFO_OVF_EN
    chk({tag, ".ovf"},      {31'd0, ovf},        {31'd0, m_ovf});
    chk({tag, ".drop_cnt"}, {24'd0, drop_cnt},   m_drop);
`endif
  endtask

  // One clock: drive inputs, advance past the edge, update the model from
  // the pre-edge state, then compare.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd, input string tag);
    bit pre_empty;
    bit pre_full;
    fr_wrreq = wr;
    rf_data  = d;
    rdreq    = rd;
    @(posedge uart_clk);
    pre_empty = (mq.size() == 0);
    pre_full  = (mq.size() == DEPTH);
    if (rd && !pre_empty) begin
      m_q  = mq.pop_front();
      m_qv = 1'b1;
    end else begin
      m_qv = 1'b0;
    end
    if (wr) begin
      if (!pre_full) begin
        mq.push_back(d);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
    fr_wrreq = 1'b0;
    rdreq    = 1'b0;
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge uart_clk);
    #3;
    rst_n = 1'b1;
    @(posedge uart_clk);
    #1;
    check_all({tag, ".post"});
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic [7:0] eq;
    logic       eqv;
    logic [4:0] eusedw;
    logic       eempty;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] b;
    rst_n    = 1'b1;
    fr_wrreq = 1'b0;
    rf_data  = 8'h00;
    rdreq    = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #3;
    check_all("reset");
    @(posedge uart_clk);
    #3;
    rst_n = 1'b1;
    @(posedge uart_clk);
    #1;

    // Single byte through, then empty-read racing a write (no write-through).
    vecs[0] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 5'd0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 5'd0, 1'b1};
    vecs[4] = '{1'b1, 8'h3C, 1'b1, 8'h55, 1'b0, 5'd1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 5'd0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 5'd0, 1'b1};
    vecs[7] = '{1'b1, 8'h99, 1'b0, 8'h3C, 1'b0, 5'd1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].wr, vecs[i].d, vecs[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tq", i),     {24'd0, q},       {24'd0, vecs[i].eq});
      chk($sformatf("vec%0d.tqv", i),    {31'd0, q_valid}, {31'd0, vecs[i].eqv});
      chk($sformatf("vec%0d.tusedw", i), {27'd0, usedw},   {27'd0, vecs[i].eusedw});
      chk($sformatf("vec%0d.tempty", i), {31'd0, empty},   {31'd0, vecs[i].eempty});
    end

    // Fill to full, drop 8'hAA, then a write+read while full also drops.
    do_reset("rst1");
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
    cycle(1'b1, 8'hAA, 1'b0, "drop");
    chk("full.flag", {31'd0, full}, 32'd1);
    chk("full.usedw", {27'd0, usedw}, 32'd16);
`ifdef UART_RX_FIFO_OVF_EN
    chk("full.ovf", {31'd0, ovf}, 32'd1);
    chk("full.drop_cnt", {24'd0, drop_cnt}, 32'd1);
`endif
    cycle(1'b1, 8'hBB, 1'b1, "full_wr_rd");
    chk("full_wr_rd.q", {24'd0, q}, 32'h00);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, "drain");
      chk($sformatf("drain%0d", i), {24'd0, q}, i);
    end
    chk("drain.empty", {31'd0, empty}, 32'd1);

    // Steady state at usedw=5 with simultaneous write and read.
    do_reset("rst2");
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, "pre5");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, "steady");
      chk("steady.usedw", {27'd0, usedw}, 32'd5);
    end

    // Mid-operation reset with 7 entries, then refill.
    do_reset("rst3");
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, "seven");
    do_reset("rst_mid");
    cycle(1'b1, 8'h42, 1'b0, "refill0");
    cycle(1'b1, 8'h43, 1'b0, "refill1");
    cycle(1'b0, 8'h00, 1'b1, "refill_rd");
    chk("refill.first", {24'd0, q}, 32'h42);

    // Two receiver-style strobes spaced like serial frames.
    do_reset("rst4");
    cycle(1'b1, 8'h55, 1'b0, "frame0");
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, "gap");
    cycle(1'b1, 8'hA3, 1'b0, "frame1");
    chk("frames.usedw", {27'd0, usedw}, 32'd2);
    cycle(1'b0, 8'h00, 1'b1, "pop0");
    chk("pop0.q", {24'd0, q}, 32'h55);
    cycle(1'b0, 8'h00, 1'b1, "pop1");
    chk("pop1.q", {24'd0, q}, 32'hA3);

    // Random traffic, write-biased phase then read-biased phase.
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom);
      if (i < 200)
        cycle(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 2) == 0), "rnd");
      else
        cycle(($urandom_range(0, 2) == 0), b, ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
